sr_latch_arbiter: RTL and testbench

//  Shares one sr_latch flag between N_REQ requesters, each asking to set or clear it.

---
 rtl/sr_latch_arbiter_if.sv | 27 ++
 rtl/sr_latch_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_sr_latch_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sr_latch_arbiter_if.sv
// sr_latch_arbiter_if: requester handshake plus the S/R/Q/Qbar link to one
// sr_latch instance. The arbiter connects through the slave modport. The
// requester side, which also owns the latch, connects through the master
// modport.
interface sr_latch_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] op;
  logic [N_REQ-1:0] gnt;
  logic             done;
  logic             err;
  logic             S;
  logic             R;
  logic             Q;
  logic             Qbar;

  modport master (
    output req, op, Q, Qbar,
    input  gnt, done, err, S, R
  );

  modport slave (
    input  req, op, Q, Qbar,
    output gnt, done, err, S, R
  );
endinterface

// File: rtl/sr_latch_arbiter.sv
// sr_latch_arbiter: shares one sr_latch flag between N_REQ requesters.
// A winner is granted from IDLE. Its set/clear op is latched, and S or R is
// pulsed for PULSE_W cycles. The registered Q/Qbar feedback is then checked
// for up to CHK_W cycles, and the operation ends with a one-cycle done or err
// pulse in DONE. S and R come from the same registered decode of op_q, so
// they are never high together.
//
// Configuration macro: SR_ARB_FIXED_PRIO_EN
//   defined   -> fixed priority, lowest index wins, no rotating pointer
//   undefined -> round-robin starting at rr_ptr (default)
module sr_latch_arbiter #(
  parameter int N_REQ   = 4,
  parameter int PULSE_W = 2,
  parameter int CHK_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  sr_latch_arbiter_if.slave bus
);

  localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_MAX = (PULSE_W > CHK_W) ? PULSE_W : CHK_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [N_REQ-1:0] GNT_ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [IDX_W-1:0] win_r;
  logic             op_q_r;
  logic             settle_r;
  logic [N_REQ-1:0] gnt_r;
  logic             done_r;
  logic             err_r;
  logic             s_r;
  logic             r_r;
  logic             q_r;
  logic             qbar_r;
  logic [IDX_W-1:0] win_s;
  logic             any_req_s;
  logic             match_s;
`ifndef SR_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0] rr_ptr_r;
`endif

`ifdef SR_ARB_FIXED_PRIO_EN
  // Lowest-index active requester wins.
  function automatic logic [IDX_W-1:0] fixed_pick(input logic [N_REQ-1:0] req_v);
    logic [IDX_W-1:0] sel;
    sel = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_v[i[IDX_W-1:0]]) begin
        sel = i[IDX_W-1:0];
      end
    end
    return sel;
  endfunction
`else
  // First active requester at or above ptr, wrapping N_REQ-1 -> 0.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req_v,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] sel;
    logic             hit;
    int               sum;
    int               idx;
    sel = '0;
    hit = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = int'(ptr) + i;
      idx = (sum >= N_REQ) ? (sum - N_REQ) : sum;
      if (!hit && req_v[idx[IDX_W-1:0]]) begin
        sel = idx[IDX_W-1:0];
        hit = 1'b1;
      end
    end
    return sel;
  endfunction
`endif

  // Winner selection and feedback comparison against the latched op.
  always_comb begin
    any_req_s = |bus.req;
`ifdef SR_ARB_FIXED_PRIO_EN
    win_s = fixed_pick(bus.req);
`else
    win_s = rr_pick(bus.req, rr_ptr_r);
`endif
    match_s = (q_r == op_q_r) && (qbar_r == ~op_q_r);
  end

  // Register the latch feedback, because the latch output is asynchronous to clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r    <= 1'b0;
      qbar_r <= 1'b0;
    end else begin
      q_r    <= bus.Q;
      qbar_r <= bus.Qbar;
    end
  end

  // Arbitration FSM: grant, pulse S/R, check feedback, report, release.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      win_r    <= '0;
      op_q_r   <= 1'b0;
      settle_r <= 1'b0;
      gnt_r    <= '0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      s_r      <= 1'b0;
      r_r      <= 1'b0;
`ifndef SR_ARB_FIXED_PRIO_EN
      rr_ptr_r <= '0;
`endif
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            gnt_r   <= GNT_ONE << win_s;
            win_r   <= win_s;
            op_q_r  <= bus.op[win_s];
            s_r     <= bus.op[win_s];
            r_r     <= ~bus.op[win_s];
            cnt_r   <= '0;
            state_r <= PULSE;
          end else begin
            gnt_r <= '0;
            s_r   <= 1'b0;
            r_r   <= 1'b0;
            cnt_r <= '0;
          end
        end
        PULSE: begin
          if (cnt_r == CNT_W'(PULSE_W - 1)) begin
            s_r      <= 1'b0;
            r_r      <= 1'b0;
            cnt_r    <= '0;
            settle_r <= 1'b1;
            state_r  <= CHECK;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        CHECK: begin
          // The first CHECK cycle only lets q_r capture the post-pulse latch value.
          if (settle_r) begin
            settle_r <= 1'b0;
          end else if (match_s) begin
            done_r  <= 1'b1;
            state_r <= DONE;
          end else if (cnt_r == CNT_W'(CHK_W - 1)) begin
            err_r   <= 1'b1;
            state_r <= DONE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        DONE: begin
          gnt_r   <= '0;
          cnt_r   <= '0;
          state_r <= IDLE;
`ifndef SR_ARB_FIXED_PRIO_EN
          rr_ptr_r <= (win_r == IDX_W'(N_REQ - 1)) ? '0 : (win_r + IDX_W'(1));
`endif
        end
        default: begin
          state_r  <= IDLE;
          gnt_r    <= '0;
          s_r      <= 1'b0;
          r_r      <= 1'b0;
          cnt_r    <= '0;
          settle_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt  = gnt_r;
  assign bus.done = done_r;
  assign bus.err  = err_r;
  assign bus.S    = s_r;
  assign bus.R    = r_r;

endmodule

// File: tb/tb_sr_latch_arbiter.sv
// tb_sr_latch_arbiter: directed tests for sr_latch_arbiter, with a
// behavioural sr_latch wired back to Q/Qbar. The stuck flag forces Q low
// so the error path can be exercised.
module tb_sr_latch_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flag = 1'b0;
  logic stuck = 1'b0;
  int   cmp_cnt = 0;
  int   err_cnt = 0;

  sr_latch_arbiter_if #(.N_REQ(4)) bus ();

  sr_latch_arbiter #(.N_REQ(4), .PULSE_W(2), .CHK_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural latch: updates mid-cycle from the registered S/R.
  always @(negedge clk) begin
    if (bus.S) flag <= 1'b1;
    else if (bus.R) flag <= 1'b0;
  end

  assign bus.Q    = stuck ? 1'b0 : flag;
  assign bus.Qbar = stuck ? 1'b1 : ~flag;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = 4'b0000;
    bus.op  = 4'b0000;
    step();
    step();
    cmp_cnt++;
    if ({bus.S, bus.R, bus.gnt, bus.done, bus.err} !== 8'h00) begin
      err_cnt++;
      $display("FAIL reset_outputs: got %b expected 00000000", {bus.S, bus.R, bus.gnt, bus.done, bus.err});
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      cmp_cnt++;
      if ({bus.S, bus.R, bus.gnt, bus.done, bus.err} !== 8'h00) begin
        err_cnt++;
        $display("FAIL idle_after_reset[%0d]: got %b expected 00000000", i, {bus.S, bus.R, bus.gnt, bus.done, bus.err});
      end
    end
  endtask

  task automatic test_set();
    logic [3:0] exp_g;
    logic       exp_s;
    logic       exp_d;
    bus.req = 4'b0001;
    bus.op  = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      step();
      exp_g = (i <= 4) ? 4'b0001 : 4'b0000;
      exp_s = (i < 2);
      exp_d = (i == 4);
      cmp_cnt++;
      if (bus.gnt !== exp_g) begin
        err_cnt++;
        $display("FAIL set_gnt[%0d]: got %b expected %b", i, bus.gnt, exp_g);
      end
      cmp_cnt++;
      if ({bus.S, bus.R} !== {exp_s, 1'b0}) begin
        err_cnt++;
        $display("FAIL set_sr[%0d]: got %b expected %b", i, {bus.S, bus.R}, {exp_s, 1'b0});
      end
      cmp_cnt++;
      if ({bus.done, bus.err} !== {exp_d, 1'b0}) begin
        err_cnt++;
        $display("FAIL set_done[%0d]: got %b expected %b", i, {bus.done, bus.err}, {exp_d, 1'b0});
      end
      if (i == 1) bus.req = 4'b0000;
    end
    cmp_cnt++;
    if ({bus.Q, bus.Qbar} !== 2'b10) begin
      err_cnt++;
      $display("FAIL set_q: got %b expected 10", {bus.Q, bus.Qbar});
    end
  endtask

  task automatic test_clear();
    logic [3:0] exp_g;
    logic       exp_r;
    logic       exp_d;
    bus.req = 4'b0100;
    bus.op  = 4'b1011;
    for (int i = 0; i < 6; i++) begin
      step();
      exp_g = (i <= 4) ? 4'b0100 : 4'b0000;
      exp_r = (i < 2);
      exp_d = (i == 4);
      cmp_cnt++;
      if (bus.gnt !== exp_g) begin
        err_cnt++;
        $display("FAIL clr_gnt[%0d]: got %b expected %b", i, bus.gnt, exp_g);
      end
      cmp_cnt++;
      if ({bus.S, bus.R} !== {1'b0, exp_r}) begin
        err_cnt++;
        $display("FAIL clr_sr[%0d]: got %b expected %b", i, {bus.S, bus.R}, {1'b0, exp_r});
      end
      cmp_cnt++;
      if ({bus.done, bus.err} !== {exp_d, 1'b0}) begin
        err_cnt++;
        $display("FAIL clr_done[%0d]: got %b expected %b", i, {bus.done, bus.err}, {exp_d, 1'b0});
      end
      if (i == 0) bus.op = 4'b1111;
      if (i == 4) bus.req = 4'b0000;
    end
    cmp_cnt++;
    if ({bus.Q, bus.Qbar} !== 2'b01) begin
      err_cnt++;
      $display("FAIL clr_q: got %b expected 01", {bus.Q, bus.Qbar});
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.req = 4'b1111;
    bus.op  = 4'b1111;
    exp_g = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      step();
      cmp_cnt++;
      if (bus.gnt !== exp_g) begin
        err_cnt++;
        $display("FAIL rr_gnt[%0d]: got %b expected %b", k, bus.gnt, exp_g);
      end
      cmp_cnt++;
      if ({bus.S, bus.R} !== 2'b10) begin
        err_cnt++;
        $display("FAIL rr_sr[%0d]: got %b expected 10", k, {bus.S, bus.R});
      end
      step();
      step();
      step();
      step();
      cmp_cnt++;
      if ({bus.done, bus.err} !== 2'b10) begin
        err_cnt++;
        $display("FAIL rr_done[%0d]: got %b expected 10", k, {bus.done, bus.err});
      end
      step();
      cmp_cnt++;
      if ({bus.gnt, bus.S, bus.R} !== 6'b000000) begin
        err_cnt++;
        $display("FAIL rr_gap[%0d]: got %b expected 000000", k, {bus.gnt, bus.S, bus.R});
      end
`ifndef SR_ARB_FIXED_PRIO_EN
      exp_g = {exp_g[2:0], exp_g[3]};
`endif
    end
    bus.req = 4'b0000;
  endtask

  task automatic test_timeout();
    logic [3:0] exp_g;
    logic       exp_s;
    logic       exp_e;
    stuck   = 1'b1;
    bus.req = 4'b0001;
    bus.op  = 4'b0001;
    for (int i = 0; i < 9; i++) begin
      step();
      exp_g = (i <= 7) ? 4'b0001 : 4'b0000;
      exp_s = (i < 2);
      exp_e = (i == 7);
      cmp_cnt++;
      if (bus.gnt !== exp_g) begin
        err_cnt++;
        $display("FAIL to_gnt[%0d]: got %b expected %b", i, bus.gnt, exp_g);
      end
      cmp_cnt++;
      if ({bus.S, bus.R} !== {exp_s, 1'b0}) begin
        err_cnt++;
        $display("FAIL to_sr[%0d]: got %b expected %b", i, {bus.S, bus.R}, {exp_s, 1'b0});
      end
      cmp_cnt++;
      if ({bus.done, bus.err} !== {1'b0, exp_e}) begin
        err_cnt++;
        $display("FAIL to_err[%0d]: got %b expected %b", i, {bus.done, bus.err}, {1'b0, exp_e});
      end
      if (i == 7) bus.req = 4'b0000;
    end
    stuck = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.req = 4'b0010;
    bus.op  = 4'b0000;
    step();
    cmp_cnt++;
    if ({bus.gnt, bus.S, bus.R} !== 6'b001001) begin
      err_cnt++;
      $display("FAIL rst_pre: got %b expected 001001", {bus.gnt, bus.S, bus.R});
    end
    rst = 1'b1;
    bus.req = 4'b0000;
    step();
    cmp_cnt++;
    if ({bus.S, bus.R, bus.gnt, bus.done, bus.err} !== 8'h00) begin
      err_cnt++;
      $display("FAIL rst_mid: got %b expected 00000000", {bus.S, bus.R, bus.gnt, bus.done, bus.err});
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      cmp_cnt++;
      if ({bus.S, bus.R, bus.gnt, bus.done, bus.err} !== 8'h00) begin
        err_cnt++;
        $display("FAIL rst_quiet[%0d]: got %b expected 00000000", i, {bus.S, bus.R, bus.gnt, bus.done, bus.err});
      end
    end
    bus.req = 4'b0100;
    bus.op  = 4'b0100;
    step();
    cmp_cnt++;
    if ({bus.gnt, bus.S, bus.R} !== 6'b010010) begin
      err_cnt++;
      $display("FAIL rst_recover_gnt: got %b expected 010010", {bus.gnt, bus.S, bus.R});
    end
    step();
    step();
    step();
    step();
    cmp_cnt++;
    if ({bus.done, bus.err} !== 2'b10) begin
      err_cnt++;
      $display("FAIL rst_recover_done: got %b expected 10", {bus.done, bus.err});
    end
    bus.req = 4'b0000;
    step();
    cmp_cnt++;
    if ({bus.gnt, bus.Q, bus.Qbar} !== 6'b000010) begin
      err_cnt++;
      $display("FAIL rst_recover_q: got %b expected 000010", {bus.gnt, bus.Q, bus.Qbar});
    end
  endtask

  initial begin
    bus.req = 4'b0000;
    bus.op  = 4'b0000;
    test_reset();
    test_set();
    test_clear();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
